// File: rtl/ras_stack_if.sv
// Fetch/backend-facing port bundle of the return address stack.
// Repair-top ports exist only when RAS_REPAIR_TOP_EN is defined.
interface ras_stack_if #(
    parameter int unsigned RAS_ENTRIES = 16
);
    localparam int unsigned IDX_W = $clog2(RAS_ENTRIES);
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam int unsigned PC_W  = 38;

    logic             link_valid;
    logic [PC_W-1:0]  link_pc38;
    logic             ret_valid;
    logic [PC_W-1:0]  ret_pc38;
    logic             ret_underflow;
    logic [IDX_W-1:0] ras_index;
    logic [CNT_W-1:0] ras_count;
    logic             update_valid;
    logic [IDX_W-1:0] update_ras_index;
    logic [CNT_W-1:0] update_ras_count;
`ifdef RAS_REPAIR_TOP_EN
    logic             update_repair;
    logic [PC_W-1:0]  update_top_pc38;
`endif

    modport master (
        output link_valid, link_pc38, ret_valid,
        output update_valid, update_ras_index, update_ras_count,
`ifdef RAS_REPAIR_TOP_EN
        output update_repair, update_top_pc38,
`endif
        input  ret_pc38, ret_underflow, ras_index, ras_count
    );

    modport slave (
        input  link_valid, link_pc38, ret_valid,
        input  update_valid, update_ras_index, update_ras_count,
`ifdef RAS_REPAIR_TOP_EN
        input  update_repair, update_top_pc38,
`endif
        output ret_pc38, ret_underflow, ras_index, ras_count
    );
endinterface

// File: rtl/ras_stack.sv
// Circular return address stack for the fetch predictor with pointer snapshot restore.
// Optional RAS_REPAIR_TOP_EN: restore also rewrites the top entry from the backend.
module ras_stack #(
    parameter int unsigned RAS_ENTRIES = 16,
    parameter logic [37:0] INIT_PC38   = 38'h0
) (
    input  logic        CLK,
    input  logic        nRST,
    ras_stack_if.slave  ras
);
    localparam int unsigned IDX_W = $clog2(RAS_ENTRIES);
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam int unsigned PC_W  = 38;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_ENTRIES);

    logic [PC_W-1:0]  entries [RAS_ENTRIES];
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr_en;
    logic [IDX_W-1:0] wr_addr;
    logic [PC_W-1:0]  wr_data;

    // Next pointer state and the single entry write; update overrides push/pop.
    always_comb begin
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_addr = idx_q;
        wr_data = ras.link_pc38;
        if (ras.update_valid) begin
            idx_d = ras.update_ras_index;
            cnt_d = (ras.update_ras_count > CNT_MAX) ? CNT_MAX : ras.update_ras_count;
`ifdef RAS_REPAIR_TOP_EN
            if (ras.update_repair) begin
                wr_en   = 1'b1;
                wr_addr = ras.update_ras_index;
                wr_data = ras.update_top_pc38;
            end
`endif
        end else if (ras.link_valid && ras.ret_valid) begin
            // Coroutine swap: replace the top in place, pointers unchanged.
            wr_en = 1'b1;
        end else if (ras.link_valid) begin
            idx_d   = idx_q + IDX_W'(1);
            cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            wr_en   = 1'b1;
            wr_addr = idx_q + IDX_W'(1);
        end else if (ras.ret_valid) begin
            // Underflowing pop still moves the index; count saturates at zero.
            idx_d = idx_q - IDX_W'(1);
            cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            idx_q <= '0;
            cnt_q <= '0;
        end else begin
            idx_q <= idx_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int unsigned i = 0; i < RAS_ENTRIES; i++) begin
                entries[i] <= INIT_PC38;
            end
        end else if (wr_en) begin
            entries[wr_addr] <= wr_data;
        end
    end

    assign ras.ret_pc38      = entries[idx_q];
    assign ras.ret_underflow = (cnt_q == '0);
    assign ras.ras_index     = idx_q;
    assign ras.ras_count     = cnt_q;
endmodule

// File: tb/tb_ras_stack.sv
// Scoreboard bench for ras_stack: driver pushes model predictions, monitor compares each cycle.
module tb_ras_stack;
    localparam int N = 16;

    typedef struct {
        logic [3:0]  idx;
        logic [4:0]  cnt;
        logic [37:0] top;
        logic        uf;
    } exp_t;

    logic CLK;
    logic nRST;
    ras_stack_if #(.RAS_ENTRIES(N)) ras ();

    ras_stack #(.RAS_ENTRIES(N), .INIT_PC38(38'h0)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .ras  (ras)
    );

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    // Reference model: a ring of N slots, a top index and a saturating count.
    int          m_idx;
    int          m_cnt;
    logic [37:0] m_ent [N];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t snap();
        exp_t e;
        e.idx = 4'(m_idx);
        e.cnt = 5'(m_cnt);
        e.top = m_ent[m_idx];
        e.uf  = (m_cnt == 0);
        return e;
    endfunction

    task automatic model_reset();
        m_idx = 0;
        m_cnt = 0;
        for (int i = 0; i < N; i++) m_ent[i] = 38'h0;
    endtask

    task automatic model_step(input bit lv, input logic [37:0] lpc, input bit rv, input bit uv,
                              input int ui, input int uc, input bit rep, input logic [37:0] top);
        if (uv) begin
            m_idx = ui;
            m_cnt = (uc > N) ? N : uc;
`ifdef RAS_REPAIR_TOP_EN
            if (rep) m_ent[ui] = top;
`else
            if (rep && top == 38'h0) m_cnt = m_cnt;
`endif
        end else if (lv && rv) begin
            m_ent[m_idx] = lpc;
        end else if (lv) begin
            m_idx = (m_idx + 1) % N;
            m_ent[m_idx] = lpc;
            if (m_cnt < N) m_cnt++;
        end else if (rv) begin
            m_idx = (m_idx + N - 1) % N;
            if (m_cnt > 0) m_cnt--;
        end
    endtask

    task automatic set_idle();
        ras.link_valid       = 1'b0;
        ras.link_pc38        = 38'h0;
        ras.ret_valid        = 1'b0;
        ras.update_valid     = 1'b0;
        ras.update_ras_index = 4'h0;
        ras.update_ras_count = 5'h0;
`ifdef RAS_REPAIR_TOP_EN
        ras.update_repair    = 1'b0;
        ras.update_top_pc38  = 38'h0;
`endif
    endtask

    // One clocked operation; expected post-edge state goes to the scoreboard.
    task automatic cycle(input bit lv, input logic [37:0] lpc, input bit rv, input bit uv,
                         input int ui, input int uc, input bit rep, input logic [37:0] top);
        ras.link_valid       = lv;
        ras.link_pc38        = lpc;
        ras.ret_valid        = rv;
        ras.update_valid     = uv;
        ras.update_ras_index = 4'(ui);
        ras.update_ras_count = 5'(uc);
`ifdef RAS_REPAIR_TOP_EN
        ras.update_repair    = rep;
        ras.update_top_pc38  = top;
`endif
        @(posedge CLK);
        model_step(lv, lpc, rv, uv, ui, uc, rep, top);
        exp_q.push_back(snap());
        #1;
        set_idle();
    endtask

    task automatic push(input logic [37:0] pc);
        cycle(1'b1, pc, 1'b0, 1'b0, 0, 0, 1'b0, 38'h0);
    endtask

    task automatic pop();
        cycle(1'b0, 38'h0, 1'b1, 1'b0, 0, 0, 1'b0, 38'h0);
    endtask

    // Monitor: outputs are valid every cycle; compare against the oldest prediction.
    initial begin
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("ras_index", 64'(ras.ras_index), 64'(e.idx));
                chk("ras_count", 64'(ras.ras_count), 64'(e.cnt));
                chk("ret_pc38", 64'(ras.ret_pc38), 64'(e.top));
                chk("ret_underflow", 64'(ras.ret_underflow), 64'(e.uf));
            end
        end
    end

    task automatic mid_burst_reset();
        @(negedge CLK);
        exp_q.delete();
        @(posedge CLK);
        #1;
        ras.link_valid = 1'b1;
        ras.link_pc38  = 38'h3FF;
        #2;
        nRST = 1'b0;
        #1;
        chk("async_rst_index", 64'(ras.ras_index), 64'h0);
        chk("async_rst_count", 64'(ras.ras_count), 64'h0);
        chk("async_rst_underflow", 64'(ras.ret_underflow), 64'h1);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        set_idle();
        model_reset();
        exp_q.push_back(snap());
    endtask

    initial begin
        nRST = 1'b0;
        set_idle();
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        nRST = 1'b1;
        exp_q.push_back(snap());

        // Basic LIFO order.
        push(38'h100);
        push(38'h200);
        push(38'h300);
        chk("dir_push_idx", 64'(ras.ras_index), 64'h3);
        chk("dir_push_top", 64'(ras.ret_pc38), 64'h300);
        pop();
        chk("dir_pop1", 64'(ras.ret_pc38), 64'h200);
        pop();
        chk("dir_pop2", 64'(ras.ret_pc38), 64'h100);
        pop();
        chk("dir_empty_uf", 64'(ras.ret_underflow), 64'h1);

        // Overflow wraps and overwrites the oldest entry.
        for (int i = 1; i <= 17; i++) push(38'(i));
        chk("dir_ovf_count", 64'(ras.ras_count), 64'd16);
        chk("dir_ovf_index", 64'(ras.ras_index), 64'h1);
        for (int i = 0; i < 16; i++) begin
            chk("dir_ovf_pop", 64'(ras.ret_pc38), 64'(17 - i));
            pop();
        end
        chk("dir_drained_uf", 64'(ras.ret_underflow), 64'h1);
        pop();
        chk("dir_underflow_cnt", 64'(ras.ras_count), 64'h0);

        // Coroutine swap.
        cycle(1'b0, 38'h0, 1'b0, 1'b1, 0, 0, 1'b0, 38'h0);
        push(38'h100);
        push(38'h200);
        chk("dir_swap_before", 64'(ras.ret_pc38), 64'h200);
        cycle(1'b1, 38'h500, 1'b1, 1'b0, 0, 0, 1'b0, 38'h0);
        chk("dir_swap_after", 64'(ras.ret_pc38), 64'h500);
        chk("dir_swap_idx", 64'(ras.ras_index), 64'h2);

        // Update wins over a same-cycle push.
        cycle(1'b1, 38'h777, 1'b0, 1'b1, 2, 2, 1'b0, 38'h0);
        chk("dir_upd_idx", 64'(ras.ras_index), 64'h2);
        chk("dir_upd_top", 64'(ras.ret_pc38), 64'h500);
        cycle(1'b0, 38'h0, 1'b0, 1'b1, 3, 31, 1'b0, 38'h0);
        chk("dir_upd_clamp", 64'(ras.ras_count), 64'd16);

`ifdef RAS_REPAIR_TOP_EN
        cycle(1'b1, 38'h999, 1'b0, 1'b1, 5, 3, 1'b1, 38'hABC);
        chk("dir_repair_top", 64'(ras.ret_pc38), 64'hABC);
`endif

        // Randomized traffic with a reset in the middle.
        for (int i = 0; i < 600; i++) begin
            int r;
            logic [37:0] pc;
            r  = int'($urandom_range(0, 99));
            pc = 38'({$urandom(), $urandom()});
            if (i == 300) mid_burst_reset();
            if (r < 35)      cycle(1'b1, pc, 1'b0, 1'b0, 0, 0, 1'b0, 38'h0);
            else if (r < 65) cycle(1'b0, pc, 1'b1, 1'b0, 0, 0, 1'b0, 38'h0);
            else if (r < 78) cycle(1'b1, pc, 1'b1, 1'b0, 0, 0, 1'b0, 38'h0);
            else if (r < 90) cycle(1'($urandom_range(0, 1)), pc, 1'($urandom_range(0, 1)), 1'b1,
                                   int'($urandom_range(0, 15)), int'($urandom_range(0, 31)),
                                   1'($urandom_range(0, 1)), 38'({$urandom(), $urandom()}));
            else             cycle(1'b0, pc, 1'b0, 1'b0, 0, 0, 1'b0, 38'h0);
        end

        repeat (2) @(negedge CLK);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
